// File: rtl/tile_sched_pkg.sv
// Shared types and sizing helpers for the tile scheduler.
package tile_sched_pkg;

    // state   | meaning
    // IDLE    | waiting for start
    // LOAD_D  | data loader filling the data buffer
    // LOAD_W  | weight loader fetching weights for one pass
    // COMPUTE | PE array running one kernel position
    // STORE   | storer writing the finished output tile
    // FIN     | one-cycle completion, done asserted
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_D  = 3'd1,
        S_LOAD_W  = 3'd2,
        S_COMPUTE = 3'd3,
        S_STORE   = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    // Counter width for a counter that spans 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_KERNEL    = 3;
    localparam int DEF_CH_GROUPS = 4;
    localparam int DEF_TILE_DIM  = 14;
    localparam int PASSES        = DEF_KERNEL * DEF_KERNEL;
    localparam int PASS_W        = cnt_w(PASSES);
    localparam int GROUP_W       = cnt_w(DEF_CH_GROUPS);
    localparam int TILE_CNT_W    = cnt_w(DEF_TILE_DIM);

endpackage

// File: rtl/tile_addr_gen.sv
// Streams TILE_DIM*TILE_DIM data-buffer reads for one kernel position.
module tile_addr_gen
    import tile_sched_pkg::*;
#(
    parameter int AW         = 8,
    parameter int KERNEL     = DEF_KERNEL,
    parameter int TILE_DIM   = DEF_TILE_DIM,
    parameter int ROW_STRIDE = 16,
    parameter int KW         = cnt_w(KERNEL),
    parameter int TW         = cnt_w(TILE_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_stream,
    input  logic          stop,
    input  logic [KW-1:0] kx,
    input  logic [KW-1:0] ky,
    input  logic [AW-1:0] base_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr
);

    logic          active;
    logic [TW-1:0] row;
    logic [TW-1:0] col;
    logic          last_col;
    logic          last_row;
    logic [AW-1:0] row_sum;
    logic [AW-1:0] col_sum;

    assign last_col = (col == TW'(TILE_DIM - 1));
    assign last_row = (row == TW'(TILE_DIM - 1));

    // Row/col scan; stop (leaving COMPUTE) wins over a fresh stream request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else if (stop) begin
            active <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else if (start_stream) begin
            active <= 1'b1;
            row    <= '0;
            col    <= '0;
        end else if (active) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row    <= '0;
                    active <= 1'b0;
                end else begin
                    row <= row + TW'(1);
                end
            end else begin
                col <= col + TW'(1);
            end
        end
    end

    assign row_sum = AW'(row) + AW'(ky);
    assign col_sum = AW'(col) + AW'(kx);
    assign rd_en   = active;
    // Address is held at zero outside the stream so idle outputs stay quiet.
    assign rd_addr = active ? (base_addr + row_sum * AW'(ROW_STRIDE) + col_sum) : '0;

endmodule

// File: rtl/tile_scheduler.sv
// Load/weight/compute/store sequencer for the conv accelerator tile loop.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int AW         = 8,
    parameter int KERNEL     = DEF_KERNEL,
    parameter int CH_GROUPS  = DEF_CH_GROUPS,
    parameter int TILE_DIM   = DEF_TILE_DIM,
    parameter int ROW_STRIDE = 16,
    parameter int GW         = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [GW-1:0] cfg_grid_w,
    input  logic [GW-1:0] cfg_grid_h,
    input  logic [AW-1:0] base_addr,
    input  logic          dl_done,
    input  logic          wl_done,
    input  logic          pe_done,
    input  logic          st_done,
    output logic          dl_start,
    output logic          wl_start,
    output logic          pe_start,
    output logic          st_start,
    output logic          new_tile,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic [GW-1:0] tile_x,
    output logic [GW-1:0] tile_y,
    output logic [2:0]    state,
    output logic          busy,
    output logic          done
);

    localparam int NPASS = KERNEL * KERNEL;
    localparam int PW    = cnt_w(NPASS);
    localparam int GRW   = cnt_w(CH_GROUPS);
    localparam int KW    = cnt_w(KERNEL);

    state_t         state_q;
    state_t         state_d;
    logic [PW-1:0]  pass_q;
    logic [GRW-1:0] group_q;
    logic [GW-1:0]  grid_w;
    logic [GW-1:0]  grid_h;
    logic           pass_last;
    logic           group_last;
    logic           tile_last;
    logic           kill;
    logic [KW-1:0]  kx;
    logic [KW-1:0]  ky;

    assign pass_last  = (pass_q == PW'(NPASS - 1));
    assign group_last = (group_q == GRW'(CH_GROUPS - 1));
    assign tile_last  = (tile_x == grid_w - GW'(1)) && (tile_y == grid_h - GW'(1));
    assign kill       = abort && (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode; each done flag only counts in its own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)   state_d = S_LOAD_D;
            S_LOAD_D:  if (dl_done) state_d = S_LOAD_W;
            S_LOAD_W:  if (wl_done) state_d = S_COMPUTE;
            S_COMPUTE: begin
                if (pe_done) begin
                    if (!pass_last)       state_d = S_LOAD_W;
                    else if (!group_last) state_d = S_LOAD_D;
                    else                  state_d = S_STORE;
                end
            end
            S_STORE:   if (st_done) state_d = tile_last ? S_FIN : S_LOAD_D;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    // Pass/group/tile counters and latched grid size (0 is promoted to 1).
    always_ff @(posedge clk) begin
        if (!rst) begin
            pass_q  <= '0;
            group_q <= '0;
            tile_x  <= '0;
            tile_y  <= '0;
            grid_w  <= '0;
            grid_h  <= '0;
        end else if (kill) begin
            pass_q  <= '0;
            group_q <= '0;
            tile_x  <= '0;
            tile_y  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        grid_w <= (cfg_grid_w == '0) ? GW'(1) : cfg_grid_w;
                        grid_h <= (cfg_grid_h == '0) ? GW'(1) : cfg_grid_h;
                    end
                end
                S_COMPUTE: begin
                    if (pe_done) begin
                        if (!pass_last) begin
                            pass_q <= pass_q + PW'(1);
                        end else begin
                            pass_q  <= '0;
                            group_q <= group_last ? '0 : group_q + GRW'(1);
                        end
                    end
                end
                S_STORE: begin
                    if (st_done && !tile_last) begin
                        if (tile_x == grid_w - GW'(1)) begin
                            tile_x <= '0;
                            tile_y <= tile_y + GW'(1);
                        end else begin
                            tile_x <= tile_x + GW'(1);
                        end
                    end
                end
                S_FIN: begin
                    tile_x <= '0;
                    tile_y <= '0;
                end
                default: ;
            endcase
        end
    end

    // Start pulses fire on the first cycle of each state entry; abort suppresses them via state_d.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dl_start <= 1'b0;
            wl_start <= 1'b0;
            pe_start <= 1'b0;
            st_start <= 1'b0;
        end else begin
            dl_start <= (state_d == S_LOAD_D)  && (state_q != S_LOAD_D);
            wl_start <= (state_d == S_LOAD_W)  && (state_q != S_LOAD_W);
            pe_start <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
            st_start <= (state_d == S_STORE)   && (state_q != S_STORE);
        end
    end

    assign kx       = KW'(32'(pass_q) % KERNEL);
    assign ky       = KW'(32'(pass_q) / KERNEL);
    assign new_tile = ((state_q == S_LOAD_W) || (state_q == S_COMPUTE))
                      && (group_q == '0) && (pass_q == '0);
    assign state    = state_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);

    tile_addr_gen #(
        .AW         (AW),
        .KERNEL     (KERNEL),
        .TILE_DIM   (TILE_DIM),
        .ROW_STRIDE (ROW_STRIDE)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .start_stream (pe_start),
        .stop         (state_d != S_COMPUTE),
        .kx           (kx),
        .ky           (ky),
        .base_addr    (base_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr)
    );

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler (3x3 kernel, 4 groups, 2x2 tile stream).
module tb_tile_scheduler;

    localparam int AW = 8;
    localparam int GW = 5;
    localparam int TD = 2;
    localparam int K  = 3;
    localparam int CG = 4;
    localparam int CH_DL = 0;
    localparam int CH_WL = 1;
    localparam int CH_PE = 2;
    localparam int CH_ST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [GW-1:0] cfg_grid_w;
    logic [GW-1:0] cfg_grid_h;
    logic [AW-1:0] base_addr;
    logic          dl_done;
    logic          wl_done;
    logic          pe_done;
    logic          st_done;
    logic          dl_start;
    logic          wl_start;
    logic          pe_start;
    logic          st_start;
    logic          new_tile;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [GW-1:0] tile_x;
    logic [GW-1:0] tile_y;
    logic [2:0]    state;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int dl_cnt   = 0;
    int wl_cnt   = 0;
    int pe_cnt   = 0;
    int st_cnt   = 0;
    int done_cnt = 0;
    int d0;

    tile_scheduler #(
        .AW       (AW),
        .KERNEL   (K),
        .CH_GROUPS(CG),
        .TILE_DIM (TD),
        .GW       (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_grid_w (cfg_grid_w),
        .cfg_grid_h (cfg_grid_h),
        .base_addr  (base_addr),
        .dl_done    (dl_done),
        .wl_done    (wl_done),
        .pe_done    (pe_done),
        .st_done    (st_done),
        .dl_start   (dl_start),
        .wl_start   (wl_start),
        .pe_start   (pe_start),
        .st_start   (st_start),
        .new_tile   (new_tile),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .state      (state),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Pulse counters (count high cycles, so a stuck pulse shows up as extra counts).
    always @(posedge clk) begin
        if (dl_start) dl_cnt <= dl_cnt + 1;
        if (wl_start) wl_cnt <= wl_cnt + 1;
        if (pe_start) pe_cnt <= pe_cnt + 1;
        if (st_start) st_cnt <= st_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic start_of(input int ch);
        case (ch)
            CH_DL:   return dl_start;
            CH_WL:   return wl_start;
            CH_PE:   return pe_start;
            default: return st_start;
        endcase
    endfunction

    task automatic wait_pulse(input int ch, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (start_of(ch)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_flag(input int ch, input int dly);
        repeat (dly) tick();
        case (ch)
            CH_DL:   dl_done = 1'b1;
            CH_WL:   wl_done = 1'b1;
            CH_PE:   pe_done = 1'b1;
            default: st_done = 1'b1;
        endcase
        tick();
        dl_done = 1'b0;
        wl_done = 1'b0;
        pe_done = 1'b0;
        st_done = 1'b0;
    endtask

    // One full output tile: CG groups x 9 passes, then store at (ex, ey).
    task automatic run_tile(input int ex, input int ey, input bit stream_chk);
        int dl0 = dl_cnt;
        int wl0 = wl_cnt;
        int pe0 = pe_cnt;
        int st0 = st_cnt;
        int nt  = 0;
        for (int g = 0; g < CG; g++) begin
            wait_pulse(CH_DL, "dl_start");
            pulse_flag(CH_DL, 2);
            for (int p = 0; p < K * K; p++) begin
                wait_pulse(CH_WL, "wl_start");
                check("new_tile_loadw", 32'(new_tile), (g == 0 && p == 0) ? 32'd1 : 32'd0);
                pulse_flag(CH_WL, p % 2);
                wait_pulse(CH_PE, "pe_start");
                check("new_tile_comp", 32'(new_tile), (g == 0 && p == 0) ? 32'd1 : 32'd0);
                if (new_tile) nt++;
                if (stream_chk && g == 0) begin
                    check("rd_en_entry", 32'(rd_en), 32'd0);
                    for (int k = 0; k < TD * TD; k++) begin
                        tick();
                        check("rd_en_on", 32'(rd_en), 32'd1);
                        check("rd_addr", 32'(rd_addr),
                              32'(16 + (k / TD + p / K) * 16 + (k % TD) + (p % K)));
                    end
                    tick();
                    check("rd_en_off", 32'(rd_en), 32'd0);
                    pulse_flag(CH_PE, 0);
                end else begin
                    pulse_flag(CH_PE, 1);
                end
            end
        end
        wait_pulse(CH_ST, "st_start");
        check("tile_x", 32'(tile_x), 32'(ex));
        check("tile_y", 32'(tile_y), 32'(ey));
        pulse_flag(CH_ST, 2);
        check("dl_pulses", 32'(dl_cnt - dl0), 32'(CG));
        check("wl_pulses", 32'(wl_cnt - wl0), 32'(CG * K * K));
        check("pe_pulses", 32'(pe_cnt - pe0), 32'(CG * K * K));
        check("st_pulses", 32'(st_cnt - st0), 32'd1);
        check("new_tile_passes", 32'(nt), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        dl_done    = 1'b0;
        wl_done    = 1'b0;
        pe_done    = 1'b0;
        st_done    = 1'b0;
        cfg_grid_w = 5'd2;
        cfg_grid_h = 5'd2;
        base_addr  = 8'h10;

        // Reset values (start/abort held active must not matter under reset).
        start = 1'b1;
        abort = 1'b1;
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_starts", 32'({dl_start, wl_start, pe_start, st_start}), 32'd0);
        check("rst_tile", 32'({tile_x, tile_y}), 32'd0);
        check("rst_new_tile", 32'(new_tile), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
        tick();
        check("idle_state", 32'(state), 32'd0);

        // Stray flags in LOAD_D, start while busy, abort, abort in IDLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("loadd_state", 32'(state), 32'd1);
        check("loadd_dl_start", 32'(dl_start), 32'd1);
        check("loadd_busy", 32'(busy), 32'd1);
        wl_done = 1'b1;
        st_done = 1'b1;
        pe_done = 1'b1;
        tick();
        wl_done = 1'b0;
        st_done = 1'b0;
        pe_done = 1'b0;
        check("stray_state", 32'(state), 32'd1);
        check("stray_dl_start", 32'(dl_start), 32'd0);
        tick();
        check("stray_state2", 32'(state), 32'd1);
        dl_done = 1'b1;
        tick();
        dl_done = 1'b0;
        check("loadw_state", 32'(state), 32'd2);
        check("loadw_wl_start", 32'(wl_start), 32'd1);
        check("loadw_new_tile", 32'(new_tile), 32'd1);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 32'(state), 32'd2);
        check("busy_start_no_dl", 32'(dl_start), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_new_tile", 32'(new_tile), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_state", 32'(state), 32'd0);
        tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Full 2x2 grid run with address stream checks on the first tile.
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_tile(0, 0, 1'b1);
        run_tile(1, 0, 1'b0);
        run_tile(0, 1, 1'b0);
        run_tile(1, 1, 1'b0);
        check("fin_done", 32'(done), 32'd1);
        check("fin_state", 32'(state), 32'd5);
        check("fin_busy", 32'(busy), 32'd1);
        tick();
        check("end_done", 32'(done), 32'd0);
        check("end_state", 32'(state), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_tile", 32'({tile_x, tile_y}), 32'd0);
        check("grid_done_count", 32'(done_cnt - d0), 32'd1);

        // Abort in the middle of a compute stream, then a clean restart.
        cfg_grid_w = 5'd1;
        cfg_grid_h = 5'd1;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pulse(CH_DL, "ab_dl_start");
        pulse_flag(CH_DL, 1);
        wait_pulse(CH_WL, "ab_wl_start");
        pulse_flag(CH_WL, 0);
        wait_pulse(CH_PE, "ab_pe_start");
        tick();
        check("ab_mid_rd_en", 32'(rd_en), 32'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_state", 32'(state), 32'd0);
        check("ab_rd_en", 32'(rd_en), 32'd0);
        check("ab_rd_addr", 32'(rd_addr), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("ab_no_done", 32'(done_cnt - d0), 32'd0);
        check("ab_idle", 32'(state), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_dl_start", 32'(dl_start), 32'd1);
        check("restart_tile", 32'({tile_x, tile_y}), 32'd0);
        run_tile(0, 0, 1'b1);
        check("restart_done", 32'(done), 32'd1);
        tick();
        check("restart_idle", 32'(state), 32'd0);

        // Start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_state", 32'(state), 32'd1);
        check("start_abort_dl", 32'(dl_start), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("start_abort_cleared", 32'(state), 32'd0);

        // Reset pulse in LOAD_W, then a width-0 grid behaves as width 1.
        cfg_grid_w = 5'd2;
        cfg_grid_h = 5'd2;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pulse(CH_DL, "rs_dl_start");
        pulse_flag(CH_DL, 0);
        wait_pulse(CH_WL, "rs_wl_start");
        check("rs_pre_new_tile", 32'(new_tile), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rs_state", 32'(state), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_new_tile", 32'(new_tile), 32'd0);
        check("rs_starts", 32'({dl_start, wl_start, pe_start, st_start}), 32'd0);
        check("rs_rd_en", 32'(rd_en), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        check("rs_tile", 32'({tile_x, tile_y}), 32'd0);
        check("rs_no_done", 32'(done_cnt - d0), 32'd0);
        cfg_grid_w = 5'd0;
        cfg_grid_h = 5'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_tile(0, 0, 1'b0);
        check("w0_done", 32'(done), 32'd1);
        check("w0_state", 32'(state), 32'd5);
        tick();
        check("w0_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
